tiny_alu_arbiter: RTL and testbench

TINY_ALU_ARBITER -- requirements
Module: tiny_alu_arbiter

---
 rtl/tiny_alu.sv | 4 +
 rtl/tiny_alu_pkg.sv | 24 ++
 rtl/tiny_alu_rr_arbiter.sv | 47 ++++
 rtl/tiny_alu_arbiter.sv | 163 ++++++++++++++++
 tb/tb_tiny_alu_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tiny_alu.sv
// rtl/tiny_alu.sv - bundle revision marker; the ALU itself lives outside this block
package tiny_alu_bundle_marker_pkg;
    localparam int BUNDLE_REV = 1;
endpackage

// File: rtl/tiny_alu_pkg.sv
// rtl/tiny_alu_pkg.sv - shared types and constants for the tiny_alu arbiter
//
// Purpose : opcode width, opcode encoding and the arbiter FSM state type,
//           imported by tiny_alu_rr_arbiter and tiny_alu_arbiter.
// Ports   : none (package).
package tiny_alu_pkg;

    localparam int OPCODE_BITS = 3;

    typedef enum logic [OPCODE_BITS-1:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_MUL = 3'd4
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/tiny_alu_rr_arbiter.sv
// rtl/tiny_alu_rr_arbiter.sv - combinational round-robin requester selection
//
// Purpose : picks the lowest-index active request at or after ptr, wrapping
//           around NUM_REQ. Purely combinational.
// Ports   : req         in  NUM_REQ  active requests
//           ptr         in  ID_BITS  first index to consider (< NUM_REQ)
//           grant       out NUM_REQ  one-hot grant, zero when no request
//           grant_idx   out ID_BITS  index of the granted requester
//           grant_valid out 1        some request was granted
module tiny_alu_rr_arbiter
    import tiny_alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_BITS = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_BITS-1:0] ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_BITS-1:0] grant_idx,
    output logic               grant_valid
);

    int                 cand;
    logic [ID_BITS-1:0] cand_idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // ptr is always below NUM_REQ, so one subtraction wraps correctly.
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = ID_BITS'(cand);
            if (!grant_valid && req[cand_idx]) begin
                grant_valid     = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/tiny_alu_arbiter.sv
// rtl/tiny_alu_arbiter.sv - round-robin arbiter sharing one tiny_alu among requesters
//
// Purpose : grants one requester at a time, drives the shared ALU with the
//           latched operands until it reports done, then holds the result on
//           the response channel until it is accepted.
//           Optional watchdog: define TINY_ALU_ARB_TIMEOUT_EN to abort an ALU
//           operation after TIMEOUT_CYCLES busy cycles with rsp_error_o=1.
// Ports   : clk_i, reset_n_i                    clock, async active-low reset
//           req_valid_i / req_ready_o           per-requester handshake
//           req_a_i, req_b_i, req_opcode_i      packed per-requester operands
//           alu_a_o, alu_b_o, alu_opcode_o      operands to the shared ALU
//           alu_start_o / alu_done_i            ALU run / completion
//           alu_result_i                        ALU result (2*INPUT_DATA_BITS)
//           rsp_valid_o / rsp_ready_i           response handshake
//           rsp_id_o, rsp_result_o, rsp_error_o response payload
module tiny_alu_arbiter
    import tiny_alu_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int INPUT_DATA_BITS = 8,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ*INPUT_DATA_BITS-1:0]   req_a_i,
    input  logic [NUM_REQ*INPUT_DATA_BITS-1:0]   req_b_i,
    input  logic [NUM_REQ*OPCODE_BITS-1:0]       req_opcode_i,
    output logic [INPUT_DATA_BITS-1:0]           alu_a_o,
    output logic [INPUT_DATA_BITS-1:0]           alu_b_o,
    output logic [OPCODE_BITS-1:0]               alu_opcode_o,
    output logic                                 alu_start_o,
    input  logic [2*INPUT_DATA_BITS-1:0]         alu_result_i,
    input  logic                                 alu_done_i,
    output logic                                 rsp_valid_o,
    input  logic                                 rsp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]           rsp_id_o,
    output logic [2*INPUT_DATA_BITS-1:0]         rsp_result_o,
    output logic                                 rsp_error_o
);

    localparam int ID_BITS = $clog2(NUM_REQ);

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("tiny_alu_arbiter needs at least two requesters");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("tiny_alu_arbiter needs TIMEOUT_CYCLES >= 1");
    end

    // Reset asserts asynchronously but releases only after two clk_i edges,
    // so the FSM never leaves reset on a metastable deassertion.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    state_e             state;
    logic [ID_BITS-1:0] rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [ID_BITS-1:0] grant_idx;
    logic               grant_valid;
    logic               accept;
    logic [ID_BITS-1:0] ptr_next;

    tiny_alu_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_BITS (ID_BITS)
    ) u_rr (
        .req         (req_valid_i),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Ready is combinational from the grant so the accept happens in the same
    // cycle the requester sees it; it is masked while reset is still held.
    assign accept      = grant_valid && (state == ST_IDLE) && rst_n;
    assign req_ready_o = accept ? grant : '0;
    assign ptr_next    = (grant_idx == ID_BITS'(NUM_REQ - 1)) ? '0 : grant_idx + ID_BITS'(1);

`ifdef TINY_ALU_ARB_TIMEOUT_EN
    localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_BITS-1:0] wd;
`else
    assign rsp_error_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            alu_start_o  <= 1'b0;
            alu_a_o      <= '0;
            alu_b_o      <= '0;
            alu_opcode_o <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_id_o     <= '0;
            rsp_result_o <= '0;
`ifdef TINY_ALU_ARB_TIMEOUT_EN
            rsp_error_o  <= 1'b0;
            wd           <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        alu_a_o      <= req_a_i[grant_idx*INPUT_DATA_BITS +: INPUT_DATA_BITS];
                        alu_b_o      <= req_b_i[grant_idx*INPUT_DATA_BITS +: INPUT_DATA_BITS];
                        alu_opcode_o <= req_opcode_i[grant_idx*OPCODE_BITS +: OPCODE_BITS];
                        rsp_id_o     <= grant_idx;
                        rr_ptr       <= ptr_next;
                        alu_start_o  <= 1'b1;
                        state        <= ST_BUSY;
`ifdef TINY_ALU_ARB_TIMEOUT_EN
                        wd           <= '0;
`endif
                    end
                end
                ST_BUSY: begin
                    // Done is checked first so it wins over a same-cycle timeout.
                    if (alu_done_i) begin
                        rsp_result_o <= alu_result_i;
                        alu_start_o  <= 1'b0;
                        rsp_valid_o  <= 1'b1;
                        state        <= ST_RESP;
`ifdef TINY_ALU_ARB_TIMEOUT_EN
                        rsp_error_o  <= 1'b0;
                    end else if (wd == WD_BITS'(TIMEOUT_CYCLES - 1)) begin
                        rsp_result_o <= '0;
                        rsp_error_o  <= 1'b1;
                        alu_start_o  <= 1'b0;
                        rsp_valid_o  <= 1'b1;
                        state        <= ST_RESP;
                    end else begin
                        wd <= wd + WD_BITS'(1);
`endif
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tiny_alu_arbiter.sv
// tb/tb_tiny_alu_arbiter.sv - self-checking bench for tiny_alu_arbiter
module tb_tiny_alu_arbiter;
    import tiny_alu_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;
    localparam int IB = 2;

    logic            clk = 1'b0;
    logic            reset_n_i = 1'b0;
    logic [N-1:0]    req_valid_i = '0;
    logic [N-1:0]    req_ready_o;
    logic [N*W-1:0]  req_a_i = '0;
    logic [N*W-1:0]  req_b_i = '0;
    logic [N*3-1:0]  req_opcode_i = '0;
    logic [W-1:0]    alu_a_o;
    logic [W-1:0]    alu_b_o;
    logic [2:0]      alu_opcode_o;
    logic            alu_start_o;
    logic [2*W-1:0]  alu_result_i = '0;
    logic            alu_done_i = 1'b0;
    logic            rsp_valid_o;
    logic            rsp_ready_i = 1'b1;
    logic [IB-1:0]   rsp_id_o;
    logic [2*W-1:0]  rsp_result_o;
    logic            rsp_error_o;

    tiny_alu_arbiter #(
        .NUM_REQ         (N),
        .INPUT_DATA_BITS (W),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .req_opcode_i (req_opcode_i),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_opcode_o (alu_opcode_o),
        .alu_start_o  (alu_start_o),
        .alu_result_i (alu_result_i),
        .alu_done_i   (alu_done_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_result_o (rsp_result_o),
        .rsp_error_o  (rsp_error_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [IB-1:0]  id;
        logic [2*W-1:0] res;
        logic           err;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int             id;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2:0]     op;
        int             delay;
        logic [2*W-1:0] res;
    } vec_t;
    vec_t vecs[7];

    // Behavioural ALU: done after alu_delay extra cycles of alu_start_o.
    int         alu_delay  = 0;
    bit         alu_hang   = 1'b0;
    bit         stray_done = 1'b0;
    int         busy_cnt   = 0;
    logic [W-1:0] cap_a, cap_b;
    logic [2:0]   cap_op;

    function automatic logic [2*W-1:0] calc(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            OP_ADD:  return {8'h00, a} + {8'h00, b};
            OP_AND:  return {8'h00, a & b};
            OP_XOR:  return {8'h00, a ^ b};
            OP_MUL:  return {8'h00, a} * {8'h00, b};
            default: return '0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (stray_done) begin
            alu_done_i   = 1'b1;
            alu_result_i = 16'hDEAD;
        end else if (alu_start_o) begin
            if (busy_cnt == 0) begin
                cap_a  = alu_a_o;
                cap_b  = alu_b_o;
                cap_op = alu_opcode_o;
            end else begin
                check("alu_a_stable", alu_a_o, cap_a);
                check("alu_b_stable", alu_b_o, cap_b);
                check("alu_op_stable", alu_opcode_o, cap_op);
            end
            if (!alu_hang && busy_cnt >= alu_delay) begin
                alu_done_i   = 1'b1;
                alu_result_i = calc(alu_opcode_o, alu_a_o, alu_b_o);
            end else begin
                alu_done_i = 1'b0;
            end
            busy_cnt++;
        end else begin
            alu_done_i = 1'b0;
            busy_cnt   = 0;
        end
    end

    // Monitor / scoreboard.
    int   accept_cnt[N];
    int   rsp_total = 0;
    exp_t e;

    always @(negedge clk) begin
        if (reset_n_i) begin
            check("ready_onehot0", 32'($onehot0(req_ready_o)), 32'd1);
            if (alu_start_o || rsp_valid_o) check("ready_zero_not_idle", req_ready_o, 0);
            for (int g = 0; g < N; g++) begin
                if (req_valid_i[g] && req_ready_o[g]) accept_cnt[g]++;
            end
            if (rsp_valid_o && rsp_ready_i) begin
                rsp_total++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: id %0d result %0h, no response expected", rsp_id_o, rsp_result_o);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", rsp_id_o, e.id);
                    check("rsp_result", rsp_result_o, e.res);
                    check("rsp_error", rsp_error_o, e.err);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid_o && cyc < 200) begin
            tick();
            cyc++;
        end
        if (!rsp_valid_o) begin
            checks++;
            errors++;
            $display("FAIL wait_rsp_timeout: rsp_valid_o %0b after %0d cycles, required 1", rsp_valid_o, cyc);
        end
    endtask

    task automatic drive(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        req_a_i[id*W +: W]      = a;
        req_b_i[id*W +: W]      = b;
        req_opcode_i[id*3 +: 3] = op;
        req_valid_i[id]         = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int cyc;
        int base;

        vecs[0] = '{2, 8'h05, 8'h03, OP_ADD, 0, 16'h0008};
        vecs[1] = '{0, 8'h0F, 8'hF0, OP_AND, 2, 16'h0000};
        vecs[2] = '{1, 8'hAA, 8'h55, OP_XOR, 1, 16'h00FF};
        vecs[3] = '{3, 8'hFF, 8'hFF, OP_MUL, 3, 16'hFE01};
        vecs[4] = '{0, 8'h10, 8'h10, OP_MUL, 0, 16'h0100};
        vecs[5] = '{1, 8'hFF, 8'hFF, OP_ADD, 0, 16'h01FE};
        vecs[6] = '{3, 8'h12, 8'h34, OP_AND, 1, 16'h0010};
        for (int g = 0; g < N; g++) accept_cnt[g] = 0;

        // Reset state, with requests pending to show ready stays low.
        req_valid_i = '1;
        tick();
        tick();
        check("rst_ready", req_ready_o, 0);
        check("rst_start", alu_start_o, 0);
        check("rst_alu_a", alu_a_o, 0);
        check("rst_alu_op", alu_opcode_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rsp_id", rsp_id_o, 0);
        check("rst_rsp_result", rsp_result_o, 0);
        check("rst_rsp_error", rsp_error_o, 0);
        req_valid_i = '0;
        reset_n_i   = 1'b1;
        tick();
        tick();
        tick();

        // Table-driven single-requester transactions.
        for (int i = 0; i < 7; i++) begin
            alu_delay = vecs[i].delay;
            exp_q.push_back('{IB'(vecs[i].id), vecs[i].res, 1'b0});
            drive(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
            #1;
            check("grant_vec", req_ready_o, 32'(1) << vecs[i].id);
            tick();
            req_valid_i = '0;
            check("start_t1", alu_start_o, 1);
            check("alu_a_vec", alu_a_o, vecs[i].a);
            check("alu_b_vec", alu_b_o, vecs[i].b);
            check("alu_op_vec", alu_opcode_o, vecs[i].op);
            wait_rsp(cyc);
            check("rsp_latency", cyc, vecs[i].delay + 1);
            check("start_dropped", alu_start_o, 0);
            tick();
        end
        check("vec_queue_empty", exp_q.size(), 0);

        // Backpressure with a stray done during RESP and another requester waiting.
        rsp_ready_i = 1'b0;
        alu_delay   = 0;
        exp_q.push_back('{IB'(1), 16'h0003, 1'b0});
        exp_q.push_back('{IB'(0), 16'h000C, 1'b0});
        drive(1, 8'h01, 8'h02, OP_ADD);
        #1;
        check("grant_bp", req_ready_o, 4'b0010);
        tick();
        req_valid_i = '0;
        drive(0, 8'h3C, 8'h0F, OP_AND);
        wait_rsp(cyc);
        stray_done = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_valid", rsp_valid_o, 1);
            check("bp_result", rsp_result_o, 16'h0003);
            check("bp_id", rsp_id_o, 1);
            check("bp_no_ready", req_ready_o, 0);
        end
        stray_done  = 1'b0;
        rsp_ready_i = 1'b1;
        tick();
        tick();
        req_valid_i = '0;
        wait_rsp(cyc);
        tick();
        check("bp_queue_empty", exp_q.size(), 0);

`ifdef TINY_ALU_ARB_TIMEOUT_EN
        // Watchdog expiry.
        alu_hang = 1'b1;
        exp_q.push_back('{IB'(2), 16'h0000, 1'b1});
        drive(2, 8'h11, 8'h22, OP_ADD);
        tick();
        req_valid_i = '0;
        cyc = 0;
        while (alu_start_o && cyc < 100) begin
            tick();
            cyc++;
        end
        check("timeout_busy_cycles", cyc, TO);
        check("timeout_rsp_valid", rsp_valid_o, 1);
        check("timeout_error", rsp_error_o, 1);
        check("timeout_result", rsp_result_o, 0);
        tick();
        alu_hang = 1'b0;
        // Done on the last allowed busy cycle wins over the timeout.
        alu_delay = TO - 1;
        exp_q.push_back('{IB'(3), 16'h0033, 1'b0});
        drive(3, 8'h11, 8'h22, OP_ADD);
        tick();
        req_valid_i = '0;
        wait_rsp(cyc);
        check("done_vs_timeout_latency", cyc, TO);
        check("done_vs_timeout_error", rsp_error_o, 0);
        tick();
        alu_delay = 0;
`else
        // Without the watchdog BUSY waits indefinitely.
        alu_hang = 1'b1;
        exp_q.push_back('{IB'(2), 16'h0033, 1'b0});
        drive(2, 8'h11, 8'h22, OP_ADD);
        tick();
        req_valid_i = '0;
        repeat (40) tick();
        check("hang_start", alu_start_o, 1);
        check("hang_no_rsp", rsp_valid_o, 0);
        check("hang_error", rsp_error_o, 0);
        alu_hang = 1'b0;
        wait_rsp(cyc);
        tick();
`endif
        check("cfg_queue_empty", exp_q.size(), 0);

        // Reset in the middle of a multiply from requester 1.
        alu_hang = 1'b1;
        drive(1, 8'hFF, 8'hFF, OP_MUL);
        tick();
        req_valid_i = '0;
        tick();
        tick();
        check("mid_busy_start", alu_start_o, 1);
        reset_n_i = 1'b0;
        #1;
        check("mid_rst_start", alu_start_o, 0);
        check("mid_rst_rsp_valid", rsp_valid_o, 0);
        check("mid_rst_alu_a", alu_a_o, 0);
        tick();
        tick();
        alu_hang  = 1'b0;
        reset_n_i = 1'b1;

        // Contention straight after reset: order must start at requester 0.
        for (int g = 0; g < N; g++) accept_cnt[g] = 0;
        exp_q.push_back('{IB'(0), 16'h0011, 1'b0});
        exp_q.push_back('{IB'(1), 16'h0012, 1'b0});
        exp_q.push_back('{IB'(2), 16'h0013, 1'b0});
        exp_q.push_back('{IB'(3), 16'h0014, 1'b0});
        exp_q.push_back('{IB'(0), 16'h0011, 1'b0});
        for (int g = 0; g < N; g++) drive(g, W'(g + 1), 8'h10, OP_ADD);
        base = rsp_total;
        cyc  = 0;
        while (rsp_total < base + 5 && cyc < 300) begin
            tick();
            cyc++;
        end
        req_valid_i = '0;
        check("contention_rsp_count", rsp_total - base, 5);
        tick();
        tick();
        check("accepts_req0", accept_cnt[0], 2);
        check("accepts_req1", accept_cnt[1], 1);
        check("accepts_req2", accept_cnt[2], 1);
        check("accepts_req3", accept_cnt[3], 1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
